// File: rtl/sb_pkg.sv
// Shared constants and the entry record for the store buffer.
package sb_pkg;
    localparam int SB_DEPTH  = 8;
    localparam int NUM_LANES = 4;
    localparam int NUM_PORTS = 2;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] wd;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_lane_compact.sv
// Prefix popcount of the store-valid lanes: each valid lane gets its slot offset from tail.
module lane_compact
    import sb_pkg::*;
#(
    parameter int NUM_LANES = sb_pkg::NUM_LANES,
    parameter int OW        = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0]         we_in,
    output logic [NUM_LANES-1:0][OW-1:0] slot_off,
    output logic [OW-1:0]                n_in
);
    logic [OW-1:0] acc;

    always_comb begin
        acc      = '0;
        slot_off = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            slot_off[i] = acc;
            acc         = acc + OW'(we_in[i]);
        end
        n_in = acc;
    end
endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: 4-wide all-or-nothing enqueue, 2-port in-order drain, load-address snoop.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES-1:0]        we_in,
    input  logic [NUM_LANES*XLEN-1:0]   adr_in,
    input  logic [NUM_LANES*XLEN-1:0]   wd_in,
    output logic                        stall,
    output logic                        we_1,
    output logic                        we_2,
    output logic [XLEN-1:0]             adr_1,
    output logic [XLEN-1:0]             wd_1,
    output logic [XLEN-1:0]             adr_2,
    output logic [XLEN-1:0]             wd_2,
    input  logic [NUM_LANES*XLEN-1:0]   ld_adr,
    output logic [NUM_LANES-1:0]        ld_hit,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(NUM_LANES + 1);

    sb_entry_t     mem_q [DEPTH];
    sb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [NUM_LANES-1:0][OW-1:0] slot_off;
    logic [OW-1:0]                n_in;
    logic [1:0]                   pops;
    logic [CW:0]                  free_slots;
    sb_entry_t                    ent0, ent1;
    logic                         pair_ok;

    lane_compact #(.NUM_LANES(NUM_LANES), .OW(OW)) u_compact (
        .we_in    (we_in),
        .slot_off (slot_off),
        .n_in     (n_in)
    );

    // Two stores to the same word never go out together; the younger waits a cycle.
    always_comb begin
        ent0    = mem_q[head_q];
        ent1    = mem_q[head_q + PW'(1)];
        we_1    = (count_q != '0);
        pair_ok = (count_q >= CW'(2)) && (ent0.adr[XLEN-1:2] != ent1.adr[XLEN-1:2]);
        we_2    = pair_ok;
        pops    = pair_ok ? 2'd2 : (we_1 ? 2'd1 : 2'd0);
        adr_1   = we_1 ? ent0.adr : '0;
        wd_1    = we_1 ? ent0.wd  : '0;
        adr_2   = we_2 ? ent1.adr : '0;
        wd_2    = we_2 ? ent1.wd  : '0;
    end

    // Slots freed by this cycle's drain are usable by this cycle's enqueue.
    always_comb begin
        free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pops);
        stall      = (CW+1)'(n_in) > free_slots;
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q + PW'(pops);
        tail_d  = tail_q;
        count_d = count_q - CW'(pops);
        if (!stall) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we_in[i]) begin
                    mem_d[tail_q + PW'(slot_off[i])] = '{adr: adr_in[i*XLEN +: XLEN],
                                                         wd:  wd_in[i*XLEN +: XLEN]};
                end
            end
            tail_d  = tail_q + PW'(n_in);
            count_d = count_d + CW'(n_in);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    logic [DEPTH-1:0]                  ent_vld;
    logic [NUM_LANES-1:0][DEPTH-1:0]   hit_mat;

    for (genvar e = 0; e < DEPTH; e++) begin : g_vld
        logic [PW-1:0] age;
        assign age        = PW'(e) - head_q;
        assign ent_vld[e] = {1'b0, age} < count_q;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            assign hit_mat[l][e] = ent_vld[e] &&
                (mem_q[e].adr[XLEN-1:2] == ld_adr[l*XLEN+2 +: XLEN-2]);
        end
        assign ld_hit[l] = |hit_mat[l];
    end

    // Load byte offsets play no part in word matching.
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_adr;

    assign count = count_q;
    assign empty = (count_q == '0);
endmodule
